// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// combinationally at accept time and held in pending registers until the latency expires.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CW-1:0]             counter;
  logic [WIDTH-1:0]          hi_q, lo_q, pend_hi, pend_lo;
  logic                      done_q;
  logic signed [WIDTH-1:0]   a_s, b_s, quo_s, rem_s;
  logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic [WIDTH-1:0]          quo_u, rem_u;
  logic [WIDTH-1:0]          res_hi, res_lo;
  logic                      b_zero, div_ovf, commit, accept;

  assign a_s    = bus.a;
  assign b_s    = bus.b;
  assign a_sx   = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign b_sx   = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
  assign quo_s  = a_s / b_s;
  assign rem_s  = a_s % b_s;
  assign quo_u  = bus.a / bus.b;
  assign rem_u  = bus.a % bus.b;

  assign b_zero  = (bus.b == '0);
  assign div_ovf = (bus.a == MIN_VAL) && (&bus.b);

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (bus.op)
      OP_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      OP_DIV: begin
        if (b_zero) begin
          res_hi = bus.a;
          res_lo = '1;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = MIN_VAL;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      OP_DIVU: begin
        if (b_zero) begin
          res_hi = bus.a;
          res_lo = '1;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

  // The edge where the counter leaves 1 both commits and may accept the next op.
  assign commit = (counter == CW'(1));
  assign accept = bus.start && ((counter == '0) || commit);

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
      if (counter != '0)
        counter <= counter - CW'(1);
      if (accept) begin
        case (bus.op)
          OP_MULT, OP_MULTU: begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            counter <= CW'(MUL_CYCLES);
          end
          OP_DIV, OP_DIVU: begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            counter <= CW'(DIV_CYCLES);
          end
          // a same-edge move is younger than the committing op, so it wins
          OP_MTHI: hi_q <= bus.a;
          OP_MTLO: lo_q <= bus.a;
          default: ;
        endcase
      end
    end
  end

  assign bus.busy = (counter != '0);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized ops
// against a behavioural model using plain wide-integer arithmetic.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, qa, q, r;
    longint unsigned pu;
    rh = '0;
    rl = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin
        q  = sa * sb;
        rh = q[63:32];
        rl = q[31:0];
      end
      3'd1: begin
        pu = {32'b0, a} * {32'b0, b};
        rh = pu[63:32];
        rl = pu[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          rl = 32'hFFFFFFFF; rh = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          rl = 32'h80000000; rh = 0;
        end else begin
          qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
          q  = ((sa < 0) != (sb < 0)) ? -qa : qa;
          r  = sa - q * sb;
          rl = q[31:0];
          rh = r[31:0];
        end
      end
      3'd3: begin
        if (b == 0) begin
          rl = 32'hFFFFFFFF; rh = a;
        end else begin
          rl = a / b; rh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Model: in-flight op retires when its remaining count hits zero; a new op may
  // be taken whenever nothing remains after that retirement.
  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_phi; m_lo = m_plo; m_done = 1'b1;
        end
      end
      if (bus.start && m_left == 0) begin
        case (bus.op)
          3'd0, 3'd1: begin ref_result(bus.op, bus.a, bus.b, m_phi, m_plo); m_left = 5; end
          3'd2, 3'd3: begin ref_result(bus.op, bus.a, bus.b, m_phi, m_plo); m_left = 10; end
          3'd4: m_hi = bus.a;
          3'd5: m_lo = bus.a;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'b0, bus.busy}, {31'b0, (m_left != 0)});
    check("done", {31'b0, bus.done}, {31'b0, m_done});
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] rh, rl;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    reset = 1'b1;

    ref_result(3'd0, 32'hFFFFFFFD, 32'd7, rh, rl);
    check("model_mult_hi", rh, 32'hFFFFFFFF);
    check("model_mult_lo", rl, 32'hFFFFFFEB);
    ref_result(3'd2, 32'hFFFFFFF9, 32'd2, rh, rl);
    check("model_div_lo", rl, 32'hFFFFFFFD);
    check("model_div_hi", rh, 32'hFFFFFFFF);

    repeat (2) @(negedge clk);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    drive(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    check("mult_busy_cycles", n, 32'd5);
    check("mult_done", {31'b0, bus.done}, 32'h1);
    check("mult_hi", bus.hi, 32'hFFFFFFFF);
    check("mult_lo", bus.lo, 32'hFFFFFFEB);

    drive(3'd1, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    check("multu_busy_cycles", n, 32'd5);
    check("multu_hi", bus.hi, 32'h6);
    check("multu_lo", bus.lo, 32'hFFFFFFEB);

    drive(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    check("div_busy_cycles", n, 32'd10);
    check("div_lo", bus.lo, 32'hFFFFFFFD);
    check("div_hi", bus.hi, 32'hFFFFFFFF);

    drive(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    check("divu0_busy_cycles", n, 32'd10);
    check("divu0_lo", bus.lo, 32'hFFFFFFFF);
    check("divu0_hi", bus.hi, 32'h7);

    drive(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    check("divovf_lo", bus.lo, 32'h80000000);
    check("divovf_hi", bus.hi, 32'h0);

    drive(3'd2, 32'd100, 32'd7);
    drive(3'd4, 32'hDEADBEEF, 32'd0);
    wait_idle(n);
    check("mthi_ignored_hi", bus.hi, 32'd2);
    check("mthi_ignored_lo", bus.lo, 32'd14);
    drive(3'd5, 32'd5, 32'd0);
    check("mtlo_lo", bus.lo, 32'd5);
    check("mtlo_busy", {31'b0, bus.busy}, 32'h0);

    drive(3'd0, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'b0, bus.done}, 32'h0);
    end

    drive(3'd0, 32'hFFFFFFFD, 32'd7);
    repeat (4) @(negedge clk);
    drive(3'd1, 32'd2, 32'd3);
    check("b2b_busy", {31'b0, bus.busy}, 32'h1);
    check("b2b_done", {31'b0, bus.done}, 32'h1);
    check("b2b_first_hi", bus.hi, 32'hFFFFFFFF);
    check("b2b_first_lo", bus.lo, 32'hFFFFFFEB);
    wait_idle(n);
    check("b2b_second_cycles", n, 32'd5);
    check("b2b_second_hi", bus.hi, 32'h0);
    check("b2b_second_lo", bus.lo, 32'h6);

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      bus.start = $urandom_range(0, 1) == 1;
      bus.op    = 3'($urandom_range(0, 7));
      bus.a     = pick();
      bus.b     = pick();
      @(negedge clk);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    wait_idle(n);
    if (n >= 64) check("final_idle_timeout", n, 32'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
